mac_perf_counter_bank: RTL and testbench

//  Per-port Ethernet MAC performance counter bank in the clk_mac domain; one instance per port.

---
 rtl/mac_perf_counter_bank.sv | 114 +++++++++++
 tb/tb_mac_perf_counter_bank.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_perf_counter_bank.sv
// Per-port MAC performance counters: TX/RX frames, bytes and RX CRC errors,
// with live outputs, indexed reads, clear-on-read and a global clear.
module mac_perf_counter_bank #(
    parameter int CNT_WIDTH = 48,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk_mac,
    input  logic                 rst_n,
    input  logic                 tx_frame_done,
    input  logic [LEN_WIDTH-1:0] tx_frame_len,
    input  logic                 rx_frame_done,
    input  logic [LEN_WIDTH-1:0] rx_frame_len,
    input  logic                 rx_crc_ok,
    input  logic                 clr_all,
    input  logic                 rd_en,
    input  logic [7:0]           rd_addr,
    input  logic                 rd_clear,
    output logic                 rd_valid,
    output logic [CNT_WIDTH-1:0] rd_data,
    output logic [CNT_WIDTH-1:0] tx_frames,
    output logic [CNT_WIDTH-1:0] tx_bytes,
    output logic [CNT_WIDTH-1:0] rx_frames,
    output logic [CNT_WIDTH-1:0] rx_crc_errs,
    output logic [CNT_WIDTH-1:0] rx_bytes
);
    localparam int NUM_CNT = 5;

    logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt_val;
    logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt_inc;
    logic [NUM_CNT-1:0]                cnt_clr;
    logic                              rx_good;
    logic                              rx_bad;
    logic [CNT_WIDTH-1:0]              rd_sel;
    logic [CNT_WIDTH-1:0]              rd_hold_reg;
    logic [CNT_WIDTH-1:0]              rd_data_reg;
    logic                              rd_pend_reg;
    logic                              rd_valid_reg;

    assign rx_good = rx_frame_done & rx_crc_ok;
    assign rx_bad  = rx_frame_done & ~rx_crc_ok;

    // Index order matches the counter IDs seen on rd_addr.
    always_comb begin
        cnt_inc    = '0;
        cnt_inc[0] = CNT_WIDTH'(tx_frame_done);
        cnt_inc[2] = CNT_WIDTH'(rx_good);
        cnt_inc[3] = CNT_WIDTH'(rx_bad);
        if (tx_frame_done) begin
            cnt_inc[1] = CNT_WIDTH'(tx_frame_len);
        end
        if (rx_good) begin
            cnt_inc[4] = CNT_WIDTH'(rx_frame_len);
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : gen_cnt
            logic [CNT_WIDTH-1:0] cnt_reg;

            assign cnt_clr[gi] = clr_all | (rd_en & rd_clear & (rd_addr == 8'(gi)));

            // Clear first, then add this cycle's event so no event is lost.
            always_ff @(posedge clk_mac or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= (cnt_clr[gi] ? '0 : cnt_reg) + cnt_inc[gi];
                end
            end

            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    always_comb begin
        rd_sel = '0;
        case (rd_addr)
            8'h00:   rd_sel = cnt_val[0];
            8'h01:   rd_sel = cnt_val[1];
            8'h02:   rd_sel = cnt_val[2];
            8'h03:   rd_sel = cnt_val[3];
            8'h04:   rd_sel = cnt_val[4];
            default: rd_sel = '0;
        endcase
    end

    // Capture the pre-event value at the request edge, present it one edge later.
    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_reg  <= 1'b0;
            rd_hold_reg  <= '0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            rd_pend_reg  <= rd_en;
            rd_valid_reg <= rd_pend_reg;
            if (rd_en) begin
                rd_hold_reg <= rd_sel;
            end
            if (rd_pend_reg) begin
                rd_data_reg <= rd_hold_reg;
            end
        end
    end

    assign rd_valid    = rd_valid_reg;
    assign rd_data     = rd_data_reg;
    assign tx_frames   = cnt_val[0];
    assign tx_bytes    = cnt_val[1];
    assign rx_frames   = cnt_val[2];
    assign rx_crc_errs = cnt_val[3];
    assign rx_bytes    = cnt_val[4];

endmodule

// File: tb/tb_mac_perf_counter_bank.sv
// Bench for mac_perf_counter_bank: a full-width instance and a 20-bit instance
// share stimulus so counter wrap can be reached in a short run.
module tb_mac_perf_counter_bank;
    localparam int CW = 48;
    localparam int WW = 20;
    localparam int LW = 16;

    logic          clk_mac = 1'b0;
    logic          rst_n = 1'b1;
    logic          tx_frame_done = 1'b0;
    logic [LW-1:0] tx_frame_len = '0;
    logic          rx_frame_done = 1'b0;
    logic [LW-1:0] rx_frame_len = '0;
    logic          rx_crc_ok = 1'b0;
    logic          clr_all = 1'b0;
    logic          rd_en = 1'b0;
    logic [7:0]    rd_addr = '0;
    logic          rd_clear = 1'b0;

    logic          rd_valid, w_rd_valid;
    logic [CW-1:0] rd_data, tx_frames, tx_bytes, rx_frames, rx_crc_errs, rx_bytes;
    logic [WW-1:0] w_rd_data, w_tx_frames, w_tx_bytes, w_rx_frames, w_rx_crc_errs, w_rx_bytes;

    mac_perf_counter_bank #(.CNT_WIDTH(CW), .LEN_WIDTH(LW)) dut (
        .clk_mac(clk_mac), .rst_n(rst_n),
        .tx_frame_done(tx_frame_done), .tx_frame_len(tx_frame_len),
        .rx_frame_done(rx_frame_done), .rx_frame_len(rx_frame_len), .rx_crc_ok(rx_crc_ok),
        .clr_all(clr_all), .rd_en(rd_en), .rd_addr(rd_addr), .rd_clear(rd_clear),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .tx_frames(tx_frames), .tx_bytes(tx_bytes), .rx_frames(rx_frames),
        .rx_crc_errs(rx_crc_errs), .rx_bytes(rx_bytes)
    );

    mac_perf_counter_bank #(.CNT_WIDTH(WW), .LEN_WIDTH(LW)) dut_w (
        .clk_mac(clk_mac), .rst_n(rst_n),
        .tx_frame_done(tx_frame_done), .tx_frame_len(tx_frame_len),
        .rx_frame_done(rx_frame_done), .rx_frame_len(rx_frame_len), .rx_crc_ok(rx_crc_ok),
        .clr_all(clr_all), .rd_en(rd_en), .rd_addr(rd_addr), .rd_clear(rd_clear),
        .rd_valid(w_rd_valid), .rd_data(w_rd_data),
        .tx_frames(w_tx_frames), .tx_bytes(w_tx_bytes), .rx_frames(w_rx_frames),
        .rx_crc_errs(w_rx_crc_errs), .rx_bytes(w_rx_bytes)
    );

    always #5 clk_mac = ~clk_mac;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model: unbounded-ish counters, masked to each instance's width on compare.
    logic [63:0] m_cnt [5];
    typedef struct {
        int          due;
        logic [63:0] data;
    } rsp_t;
    rsp_t        exp_q[$];
    bit          resp_exp = 1'b0;
    logic [63:0] last_rd = '0;

    function automatic logic [63:0] msk(input int w);
        return (w != 0) ? 64'h0000_0000_000F_FFFF : 64'h0000_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] dut_cnt(input int i, input int w);
        logic [63:0] v;
        v = '0;
        case (i)
            0: v = (w != 0) ? 64'(w_tx_frames)   : 64'(tx_frames);
            1: v = (w != 0) ? 64'(w_tx_bytes)    : 64'(tx_bytes);
            2: v = (w != 0) ? 64'(w_rx_frames)   : 64'(rx_frames);
            3: v = (w != 0) ? 64'(w_rx_crc_errs) : 64'(rx_crc_errs);
            default: v = (w != 0) ? 64'(w_rx_bytes) : 64'(rx_bytes);
        endcase
        return v;
    endfunction

    function automatic logic [63:0] dut_rd(input int w);
        return (w != 0) ? 64'(w_rd_data) : 64'(rd_data);
    endfunction

    function automatic logic dut_vld(input int w);
        return (w != 0) ? w_rd_valid : rd_valid;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_cnt[i] = '0;
        exp_q.delete();
        resp_exp = 1'b0;
        last_rd  = '0;
    endtask

    // Advance one clock edge, apply the edge's effect to the model, sample at +1.
    task automatic step();
        rsp_t r;
        int   a;
        @(posedge clk_mac);
        if (rst_n) begin
            cyc++;
            resp_exp = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                resp_exp = 1'b1;
                r = exp_q.pop_front();
                last_rd = r.data;
            end
            a = int'(rd_addr);
            if (rd_en) begin
                r.due  = cyc + 1;
                r.data = (a < 5) ? m_cnt[a] : 64'd0;
                exp_q.push_back(r);
            end
            for (int i = 0; i < 5; i++) begin
                if (clr_all || (rd_en && rd_clear && a == i)) m_cnt[i] = '0;
            end
            if (tx_frame_done) begin
                m_cnt[0] = m_cnt[0] + 64'd1;
                m_cnt[1] = m_cnt[1] + 64'(tx_frame_len);
            end
            if (rx_frame_done && rx_crc_ok) begin
                m_cnt[2] = m_cnt[2] + 64'd1;
                m_cnt[4] = m_cnt[4] + 64'(rx_frame_len);
            end
            if (rx_frame_done && !rx_crc_ok) m_cnt[3] = m_cnt[3] + 64'd1;
        end
        #1;
    endtask

    task automatic cycle(input bit tx, input int txl, input bit rx, input int rxl, input bit ok,
                         input bit ca, input bit re, input int ra, input bit rc);
        tx_frame_done = tx;  tx_frame_len = LW'(txl);
        rx_frame_done = rx;  rx_frame_len = LW'(rxl);  rx_crc_ok = ok;
        clr_all = ca;  rd_en = re;  rd_addr = 8'(ra);  rd_clear = rc;
        step();
        tx_frame_done = 1'b0;  rx_frame_done = 1'b0;  clr_all = 1'b0;
        rd_en = 1'b0;  rd_clear = 1'b0;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (dut_cnt(i, w) !== 64'd0) begin
                    n_bad++;
                    $display("FAIL reset_cnt%0d w%0d: got %h expected 0", i, w, dut_cnt(i, w));
                end
            end
            n_cmp++;
            if (dut_vld(w) !== 1'b0 || dut_rd(w) !== 64'd0) begin
                n_bad++;
                $display("FAIL reset_rd w%0d: got valid=%b data=%h expected 0/0", w, dut_vld(w), dut_rd(w));
            end
        end
        @(posedge clk_mac);
        @(posedge clk_mac);
        #1 rst_n = 1'b1;
        model_reset();
        idle();
        for (int w = 0; w < 2; w++) begin
            n_cmp++;
            if (dut_cnt(0, w) !== 64'd0 || dut_cnt(4, w) !== 64'd0) begin
                n_bad++;
                $display("FAIL post_reset_idle w%0d: got %h/%h expected 0/0", w, dut_cnt(0, w), dut_cnt(4, w));
            end
        end
        $display("reset: done, %0d compared", n_cmp);
    endtask

    task automatic test_tx();
        logic [63:0] e [5];
        cycle(1, 64, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1500, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        e = '{64'd3, 64'd1564, 64'd0, 64'd0, 64'd0};
        for (int w = 0; w < 2; w++) for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (dut_cnt(i, w) !== e[i]) begin
                n_bad++;
                $display("FAIL tx_cnt%0d w%0d: got %0d expected %0d", i, w, dut_cnt(i, w), e[i]);
            end
        end
        $display("tx: tx_frames=%0d tx_bytes=%0d", tx_frames, tx_bytes);
    endtask

    task automatic test_rx();
        logic [63:0] e [5];
        cycle(0, 0, 1, 100, 1, 0, 0, 0, 0);
        cycle(0, 0, 1, 100, 0, 0, 0, 0, 0);
        e = '{64'd3, 64'd1564, 64'd1, 64'd1, 64'd100};
        for (int w = 0; w < 2; w++) for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (dut_cnt(i, w) !== e[i]) begin
                n_bad++;
                $display("FAIL rx_cnt%0d w%0d: got %0d expected %0d", i, w, dut_cnt(i, w), e[i]);
            end
        end
        $display("rx: rx_frames=%0d rx_crc_errs=%0d rx_bytes=%0d", rx_frames, rx_crc_errs, rx_bytes);
    endtask

    task automatic test_clear_all();
        logic [63:0] e [5];
        // clr_all with TX/RX events and a read of tx_bytes on the same edge
        cycle(1, 7, 1, 9, 1, 1, 1, 1, 0);
        e = '{64'd1, 64'd7, 64'd1, 64'd0, 64'd9};
        for (int w = 0; w < 2; w++) for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (dut_cnt(i, w) !== e[i]) begin
                n_bad++;
                $display("FAIL clrall_cnt%0d w%0d: got %0d expected %0d", i, w, dut_cnt(i, w), e[i]);
            end
        end
        idle();
        for (int w = 0; w < 2; w++) begin
            n_cmp++;
            if (dut_vld(w) !== 1'b1 || dut_rd(w) !== 64'd1564) begin
                n_bad++;
                $display("FAIL clrall_read w%0d: got valid=%b data=%0d expected 1/1564", w, dut_vld(w), dut_rd(w));
            end
        end
        $display("clear_all: read returned %0d", rd_data);
    endtask

    task automatic test_wrap();
        cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 16; k++) cycle(1, 'hFFFF, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (64'(w_tx_bytes) !== 64'h000F_FFF0 || 64'(w_tx_frames) !== 64'd16) begin
            n_bad++;
            $display("FAIL wrap_preload: got bytes=%h frames=%0d expected fffff0/16", w_tx_bytes, w_tx_frames);
        end
        cycle(1, 'h20, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (64'(w_tx_bytes) !== 64'h10 || 64'(w_tx_frames) !== 64'd17) begin
            n_bad++;
            $display("FAIL wrap_narrow: got bytes=%h frames=%0d expected 10/17", w_tx_bytes, w_tx_frames);
        end
        n_cmp++;
        if (64'(tx_bytes) !== 64'h0010_0010 || 64'(tx_frames) !== 64'd17) begin
            n_bad++;
            $display("FAIL wrap_full: got bytes=%h frames=%0d expected 100010/17", tx_bytes, tx_frames);
        end
        $display("wrap: narrow tx_bytes=%h full tx_bytes=%h", w_tx_bytes, tx_bytes);
    endtask

    task automatic test_clear_on_read();
        cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) cycle(1, 10, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (tx_frames !== 48'd5) begin
            n_bad++;
            $display("FAIL cor_preload: got %0d expected 5", tx_frames);
        end
        cycle(1, 10, 0, 0, 0, 0, 1, 0, 1);
        n_cmp++;
        if (tx_frames !== 48'd1 || tx_bytes !== 48'd60 || rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL cor_after_edge: got frames=%0d bytes=%0d valid=%b expected 1/60/0",
                     tx_frames, tx_bytes, rd_valid);
        end
        idle();
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 48'd5) begin
            n_bad++;
            $display("FAIL cor_response: got valid=%b data=%0d expected 1/5", rd_valid, rd_data);
        end
        idle();
        n_cmp++;
        if (rd_valid !== 1'b0 || rd_data !== 48'd5) begin
            n_bad++;
            $display("FAIL cor_hold: got valid=%b data=%0d expected 0/5", rd_valid, rd_data);
        end
        $display("clear_on_read: tx_frames=%0d read=%0d", tx_frames, rd_data);
    endtask

    task automatic test_back_to_back();
        bit          ev [5];
        logic [63:0] ed [5];
        cycle(0, 0, 0, 0, 0, 0, 1, 7, 0);
        idle();
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 48'd0 || w_rd_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL unmapped: got valid=%b data=%h expected 1/0", rd_valid, rd_data);
        end
        cycle(0, 0, 1, 200, 1, 0, 0, 0, 0);
        ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        ed = '{64'd0, 64'd1, 64'd1, 64'd240, 64'd240};
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: cycle(1, 5, 0, 0, 0, 0, 1, 0, 0);
                1: cycle(0, 0, 1, 40, 1, 0, 1, 2, 0);
                2: cycle(0, 0, 0, 0, 0, 0, 1, 4, 0);
                default: idle();
            endcase
            n_cmp++;
            if (rd_valid !== ev[k] || (ev[k] && rd_data !== ed[k][CW-1:0])) begin
                n_bad++;
                $display("FAIL b2b_step%0d: got valid=%b data=%0d expected %b/%0d", k, rd_valid, rd_data, ev[k], ed[k]);
            end
        end
        n_cmp++;
        if (rd_data !== 48'd240) begin
            n_bad++;
            $display("FAIL b2b_hold: got %0d expected 240", rd_data);
        end
        $display("back_to_back: last response %0d", rd_data);
    endtask

    task automatic test_random();
        int bad0;
        bad0 = n_bad;
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 1), $urandom_range(0, 65535),
                  $urandom_range(0, 1), $urandom_range(0, 65535), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 31) == 0, $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 3) == 0);
            for (int w = 0; w < 2; w++) begin
                n_cmp++;
                if (dut_vld(w) !== resp_exp || dut_rd(w) !== (last_rd & msk(w))) begin
                    n_bad++;
                    $display("FAIL rand_rd cyc%0d w%0d: got valid=%b data=%h expected %b/%h",
                             cyc, w, dut_vld(w), dut_rd(w), resp_exp, last_rd & msk(w));
                end
                for (int i = 0; i < 5; i++) begin
                    n_cmp++;
                    if (dut_cnt(i, w) !== (m_cnt[i] & msk(w))) begin
                        n_bad++;
                        $display("FAIL rand_cnt%0d cyc%0d w%0d: got %h expected %h",
                                 i, cyc, w, dut_cnt(i, w), m_cnt[i] & msk(w));
                    end
                end
            end
        end
        $display("random: 400 cycles, %0d new mismatches", n_bad - bad0);
    endtask

    task automatic test_async_reset();
        cycle(1, 100, 1, 50, 1, 0, 0, 0, 0);
        cycle(1, 100, 0, 0, 0, 0, 1, 1, 0);
        cycle(1, 100, 1, 60, 0, 0, 1, 2, 0);
        #2 rst_n = 1'b0;
        #1;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (dut_cnt(i, w) !== 64'd0) begin
                    n_bad++;
                    $display("FAIL async_rst_cnt%0d w%0d: got %h expected 0", i, w, dut_cnt(i, w));
                end
            end
            n_cmp++;
            if (dut_vld(w) !== 1'b0 || dut_rd(w) !== 64'd0) begin
                n_bad++;
                $display("FAIL async_rst_rd w%0d: got valid=%b data=%h expected 0/0", w, dut_vld(w), dut_rd(w));
            end
        end
        model_reset();
        @(posedge clk_mac);
        #1 rst_n = 1'b1;
        cycle(1, 33, 0, 0, 0, 0, 0, 0, 0);
        for (int w = 0; w < 2; w++) begin
            n_cmp++;
            if (dut_cnt(0, w) !== 64'd1 || dut_cnt(1, w) !== 64'd33 || dut_cnt(2, w) !== 64'd0 ||
                dut_vld(w) !== 1'b0) begin
                n_bad++;
                $display("FAIL release_strobe w%0d: got frames=%0d bytes=%0d rxf=%0d valid=%b expected 1/33/0/0",
                         w, dut_cnt(0, w), dut_cnt(1, w), dut_cnt(2, w), dut_vld(w));
            end
        end
        idle();
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL release_no_stale_rsp: got valid=%b expected 0", rd_valid);
        end
        $display("async_reset: tx_frames=%0d tx_bytes=%0d after release", tx_frames, tx_bytes);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_tx();
        test_rx();
        test_clear_all();
        test_wrap();
        test_clear_on_read();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
